// File: rtl/iiitb_gc_pkg.sv
// Shared definitions for the iiitb Gray counter run controller.
// Provides the default counter width, the controller state encoding and
// a reference Gray-to-binary conversion function.
package iiitb_gc_pkg;

   localparam int GC_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_CLEAR = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      CLEAR = ST_CLEAR,
      RUN   = ST_RUN,
      DONE  = ST_DONE
   } gc_state_t;

   // Binary bit i is the XOR of every Gray bit at or above position i.
   function automatic logic [GC_WIDTH-1:0] gray2bin(input logic [GC_WIDTH-1:0] gray);
      logic [GC_WIDTH-1:0] bin;
      for (int i = 0; i < GC_WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/iiitb_gc_g2b.sv
// Combinational WIDTH-bit Gray-to-binary converter.
// Turns the counter's Gray output back into a step count so the controller
// can compare it with the number of enables it has issued.
module iiitb_gc_g2b #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each binary bit is the parity of the Gray bits from its position upwards.
   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/iiitb_gc_ctrl.sv
// Run controller / sequencer for the 8-bit Gray counter iiitb_gc.
// Accepts run commands over valid/ready, pulses the counter reset once,
// issues exactly cmd_len enables, checks every Gray output against the
// issued step count and reports done, aborted and a sticky err flag.
// Optional feature: define GC_CTRL_PAUSE_EN to add a 'pause' input that
// holds off enables combinationally while in RUN.
module iiitb_gc_ctrl
   import iiitb_gc_pkg::*;
#(
   parameter int WIDTH = GC_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_len,
   input  logic             cmd_cont,
   input  logic             stop,
   output logic             gc_reset,
   output logic             gc_enable,
   input  logic [WIDTH-1:0] gray_in,
`ifdef GC_CTRL_PAUSE_EN
   input  logic             pause,
`endif
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic             err,
   output logic [WIDTH-1:0] steps_done
);

   gc_state_t        state;
   logic [WIDTH-1:0] len_q;
   logic             cont_q;
   logic             run_q;
   logic             check_q;
   logic             advance;
   logic             last_step;
   logic             mismatch;
   logic [WIDTH-1:0] gray_bin;

   iiitb_gc_g2b #(
      .WIDTH(WIDTH)
   ) u_g2b (
      .gray(gray_in),
      .bin (gray_bin)
   );

`ifdef GC_CTRL_PAUSE_EN
   assign advance = run_q & ~pause;
`else
   assign advance = run_q;
`endif

   assign gc_enable = advance;
   assign last_step = (steps_done == (len_q - WIDTH'(1)));
   assign mismatch  = check_q && (gray_bin != steps_done);

   // Sequencer: state, step counter, mismatch tracking and all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         cmd_ready  <= 1'b1;
         gc_reset   <= 1'b1;
         run_q      <= 1'b0;
         check_q    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         aborted    <= 1'b0;
         err        <= 1'b0;
         steps_done <= '0;
         len_q      <= '0;
         cont_q     <= 1'b0;
      end else begin
         gc_reset <= 1'b0;
         done     <= 1'b0;
         check_q  <= 1'b0;
         if (mismatch) begin
            err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  len_q      <= cmd_len;
                  cont_q     <= cmd_cont;
                  err        <= 1'b0;
                  aborted    <= 1'b0;
                  steps_done <= '0;
                  cmd_ready  <= 1'b0;
                  busy       <= 1'b1;
                  if (cmd_len == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= CLEAR;
                     gc_reset <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               state   <= RUN;
               run_q   <= 1'b1;
               check_q <= 1'b1;
            end
            RUN: begin
               if (advance) begin
                  steps_done <= steps_done + WIDTH'(1);
                  check_q    <= 1'b1;
               end
               if (stop) begin
                  state   <= DONE;
                  run_q   <= 1'b0;
                  aborted <= 1'b1;
                  done    <= 1'b1;
               end else if (advance && last_step) begin
                  state <= DONE;
                  run_q <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               if (cont_q && !aborted && !stop) begin
                  steps_done <= '0;
                  if (len_q == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= CLEAR;
                     gc_reset <= 1'b1;
                  end
               end else begin
                  state     <= IDLE;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               run_q     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iiitb_gc_ctrl.sv
// Testbench for iiitb_gc_ctrl.
// The bench plays the Gray counter itself (with an injectable bit flip) and
// predicts each command's cycle timeline from its length, continuous-mode
// repeat count, stop point and flip point.
module tb_iiitb_gc_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         cmd_valid;
   logic         cmd_ready;
   logic [W-1:0] cmd_len;
   logic         cmd_cont;
   logic         stop;
   logic         gc_reset;
   logic         gc_enable;
   logic [W-1:0] gray_in;
   logic         busy;
   logic         done;
   logic         aborted;
   logic         err;
   logic [W-1:0] steps_done;
`ifdef GC_CTRL_PAUSE_EN
   logic         pause;
   int           runCycles;
`endif

   logic [W-1:0] cntModel;
   logic         faultFlip;
   bit           expErr;
   int           checkCount = 0;
   int           errorCount = 0;

   iiitb_gc_ctrl #(
      .WIDTH(W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_len   (cmd_len),
      .cmd_cont  (cmd_cont),
      .stop      (stop),
      .gc_reset  (gc_reset),
      .gc_enable (gc_enable),
      .gray_in   (gray_in),
`ifdef GC_CTRL_PAUSE_EN
      .pause     (pause),
`endif
      .busy      (busy),
      .done      (done),
      .aborted   (aborted),
      .err       (err),
      .steps_done(steps_done)
   );

   always #5 clk = ~clk;

   // Behavioural stand-in for the Gray counter the controller drives.
   always @(posedge clk) begin
      if (gc_reset) cntModel <= '0;
      else if (gc_enable) cntModel <= cntModel + 1'b1;
   end

   assign gray_in = (cntModel ^ (cntModel >> 1)) ^ {{(W-1){1'b0}}, faultFlip};

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   // One clock: a flip present in this cycle must make err sticky afterwards.
   task automatic tick();
      @(posedge clk);
      if (faultFlip) expErr = 1'b1;
      @(negedge clk);
      faultFlip = 1'b0;
      stop      = 1'b0;
   endtask

   // Offer a command in IDLE and complete the handshake.
   task automatic applyStimulus(input int len, input bit cont);
      cmd_valid = 1'b1;
      cmd_len   = len[W-1:0];
      cmd_cont  = cont;
      checkOutput("accept_ready", cmd_ready, 1);
      tick();
      cmd_valid = 1'b0;
      cmd_len   = W'($urandom);
      cmd_cont  = 1'($urandom);
      expErr    = 1'b0;
   endtask

   // Run a full command, checking every cycle. flipAt < 0 means no flip.
   task automatic runCommand(input int len, input bit cont, input int runs, input int stopAt, input int flipAt);
      int n;
      bit stopped;
      bit last;
      n = 0;
      stopped = 1'b0;
      applyStimulus(len, cont);
      if (len == 0) begin
         checkOutput("null_done", done, 1);
         checkOutput("null_gc_reset", gc_reset, 0);
         checkOutput("null_enable", gc_enable, 0);
         checkOutput("null_steps", steps_done, 0);
         checkOutput("null_busy", busy, 1);
         tick();
         checkOutput("null_idle_ready", cmd_ready, 1);
         checkOutput("null_idle_done", done, 0);
         return;
      end
      for (int r = 0; r < runs; r++) begin
         last    = (r == runs - 1);
         stopped = last && (stopAt > 0);
         n       = stopped ? stopAt : len;
         checkOutput("clear_gc_reset", gc_reset, 1);
         checkOutput("clear_enable", gc_enable, 0);
         checkOutput("clear_busy", busy, 1);
         checkOutput("clear_ready", cmd_ready, 0);
         checkOutput("clear_steps", steps_done, 0);
         checkOutput("clear_aborted", aborted, 0);
         checkOutput("clear_err", err, expErr);
         tick();
         for (int k = 0; k < n; k++) begin
            if (stopped && k == n - 1) stop = 1'b1;
            if (r == 0 && k == flipAt) faultFlip = 1'b1;
            checkOutput("run_enable", gc_enable, 1);
            checkOutput("run_gc_reset", gc_reset, 0);
            checkOutput("run_steps", steps_done, k);
            checkOutput("run_done", done, 0);
            checkOutput("run_err", err, expErr);
            tick();
         end
         if (r == 0 && n == flipAt) faultFlip = 1'b1;
         if (last && cont && !stopped) stop = 1'b1;
         checkOutput("done_pulse", done, 1);
         checkOutput("done_steps", steps_done, n);
         checkOutput("done_aborted", aborted, stopped);
         checkOutput("done_enable", gc_enable, 0);
         checkOutput("done_ready", cmd_ready, 0);
         checkOutput("done_err", err, expErr);
         tick();
      end
      checkOutput("idle_ready", cmd_ready, 1);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
      checkOutput("idle_steps", steps_done, n);
      checkOutput("idle_aborted", aborted, stopped);
      checkOutput("idle_err", err, expErr);
   endtask

   // Directed scenarios followed by randomized commands.
   initial begin
      int len;
      int runs;
      int stopAt;
      int flipAt;
      bit cont;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_len   = '0;
      cmd_cont  = 1'b0;
      stop      = 1'b0;
      faultFlip = 1'b0;
      expErr    = 1'b0;
`ifdef GC_CTRL_PAUSE_EN
      pause     = 1'b0;
      runCycles = 0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_gc_reset", gc_reset, 1);
      checkOutput("rst_enable", gc_enable, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_aborted", aborted, 0);
      checkOutput("rst_err", err, 0);
      checkOutput("rst_steps", steps_done, 0);
      reset = 1'b0;
      tick();
      checkOutput("post_rst_gc_reset", gc_reset, 0);
      checkOutput("post_rst_ready", cmd_ready, 1);

      $display("[TB] directed commands");
      runCommand(5, 1'b0, 1, 0, -1);
      runCommand(0, 1'b0, 1, 0, -1);
      runCommand(200, 1'b0, 1, 50, -1);
      runCommand(3, 1'b1, 3, 0, -1);
      runCommand(10, 1'b0, 1, 0, 7);
      repeat (3) tick();
      checkOutput("err_sticky", err, 1);
      runCommand(4, 1'b0, 1, 0, -1);
      runCommand(255, 1'b0, 1, 0, -1);

      $display("[TB] reset during run");
      applyStimulus(20, 1'b0);
      tick();
      repeat (10) tick();
      checkOutput("pre_reset_steps", steps_done, 10);
      reset = 1'b1;
      tick();
      checkOutput("midrst_gc_reset", gc_reset, 1);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_enable", gc_enable, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_steps", steps_done, 0);
      reset = 1'b0;
      tick();
      checkOutput("midrst_idle_done", done, 0);
      checkOutput("midrst_idle_ready", cmd_ready, 1);
      checkOutput("midrst_idle_busy", busy, 0);

`ifdef GC_CTRL_PAUSE_EN
      $display("[TB] pause during run");
      applyStimulus(6, 1'b0);
      tick();
      for (int i = 0; i < 50 && !done; i++) begin
         pause = (runCycles >= 2 && runCycles < 6);
         runCycles++;
         tick();
      end
      pause = 1'b0;
      checkOutput("pause_done", done, 1);
      checkOutput("pause_run_cycles", runCycles, 10);
      checkOutput("pause_steps", steps_done, 6);
      tick();
`endif

      $display("[TB] randomized commands");
      for (int t = 0; t < 20; t++) begin
         len    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
         cont   = (len != 0) && ($urandom_range(0, 3) == 0);
         runs   = cont ? int'($urandom_range(2, 3)) : 1;
         stopAt = (len != 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len)) : 0;
         flipAt = (len != 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(0, len)) : -1;
         runCommand(len, cont, runs, stopAt, flipAt);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
